watchdog_timer: RTL

WATCHDOG_TIMER -- requirements
Module: watchdog_timer

---
 rtl/watchdog_timer_pkg.sv | 42 ++++
 rtl/watchdog_timer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/watchdog_timer_pkg.sv
// Shared peripheral definitions for the watchdog timer: state codes,
// register offsets, CTRL bit positions and the default kick key.
package watchdog_timer_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WARN = 2'd2,
    ST_BITE = 2'd3
  } wdt_state_e;

  // Register offsets as seen on ADDR[3:2]
  localparam logic [1:0] OFF_CTRL  = 2'd0;
  localparam logic [1:0] OFF_LOAD  = 2'd1;
  localparam logic [1:0] OFF_COUNT = 2'd2;
  localparam logic [1:0] OFF_KICK  = 2'd3;

  // CTRL register bit positions
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_IM_BIT    = 1;
  localparam int unsigned CTRL_RSTEN_BIT = 2;
  localparam int unsigned CTRL_STATE_LSB = 4;

  localparam logic [DATA_W-1:0] KICK_KEY_DEFAULT = 32'h5A5A_5A5A;

  // Assemble the CTRL read-back word; unused bits read as zero
  function automatic logic [DATA_W-1:0] ctrl_readback(input wdt_state_e st,
                                                      input logic en,
                                                      input logic im,
                                                      input logic rsten);
    logic [DATA_W-1:0] w;
    w                        = '0;
    w[CTRL_EN_BIT]           = en;
    w[CTRL_IM_BIT]           = im;
    w[CTRL_RSTEN_BIT]        = rsten;
    w[CTRL_STATE_LSB +: 2]   = st;
    return w;
  endfunction

endpackage

// File: rtl/watchdog_timer.sv
// Bus-mapped watchdog timer: a RUN countdown, a WARN countdown with optional
// interrupt, and a BITE state that can request a system reset. Register
// decode and the state machine share this one module.
module watchdog_timer
  import watchdog_timer_pkg::*;
#(
  parameter logic [31:0] KICK_KEY = KICK_KEY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        We,
  input  logic [31:0] ADDR,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        rst_req
);

  wdt_state_e        state_q, state_d;
  logic              en_q, en_d;
  logic              im_q, im_d;
  logic              rsten_q, rsten_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              irq_q, irq_d;
  logic              rst_req_q, rst_req_d;

  logic              wr_ctrl_c;
  logic              wr_load_c;
  logic              wr_kick_c;
  logic              kick_ok_c;
  logic              unused_addr_bits;

  // Only ADDR[3:2] select a register; the rest of the address is don't-care
  assign unused_addr_bits = ^{ADDR[31:4], ADDR[1:0]};

  // Write strobes per register
  assign wr_ctrl_c = We && (ADDR[3:2] == OFF_CTRL);
  assign wr_load_c = We && (ADDR[3:2] == OFF_LOAD);
  assign wr_kick_c = We && (ADDR[3:2] == OFF_KICK);
  assign kick_ok_c = (Din == KICK_KEY);

  // Next-state, register updates and registered output values
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    im_d      = im_q;
    rsten_d   = rsten_q;
    load_d    = load_q;
    count_d   = count_q;
    irq_d     = (state_q == ST_WARN) && im_q;
    rst_req_d = (state_q == ST_BITE) && rsten_q;

    // LOAD never touches COUNT; it only matters at the next reload
    if (wr_load_c) begin
      load_d = Din;
    end

    if (wr_ctrl_c) begin
      en_d    = Din[CTRL_EN_BIT];
      im_d    = Din[CTRL_IM_BIT];
      rsten_d = Din[CTRL_RSTEN_BIT];
    end

    unique case (state_q)
      ST_IDLE: begin
        // Arming requires a non-zero reload value, otherwise EN is just stored
        if (wr_ctrl_c && Din[CTRL_EN_BIT] && (load_q != '0)) begin
          count_d = load_q;
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_WARN: begin
        // Priority: EN-clear, then kick, then the zero check, then decrement
        if (wr_ctrl_c && !Din[CTRL_EN_BIT]) begin
          state_d = ST_IDLE;
        end else if (wr_kick_c) begin
          if (kick_ok_c) begin
            count_d = load_q;
            state_d = ST_RUN;
          end else begin
            state_d = ST_BITE;
          end
        end else if (count_q == '0) begin
          if (state_q == ST_RUN) begin
            count_d = load_q;
            state_d = ST_WARN;
          end else begin
            state_d = ST_BITE;
          end
        end else begin
          count_d = count_q - DATA_W'(1);
        end
      end

      ST_BITE: begin
        // Only a CTRL write (or reset) leaves BITE; kicks are ignored
        if (wr_ctrl_c) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and register flops with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      im_q      <= 1'b0;
      rsten_q   <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      irq_q     <= 1'b0;
      rst_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      im_q      <= im_d;
      rsten_q   <= rsten_d;
      load_q    <= load_d;
      count_q   <= count_d;
      irq_q     <= irq_d;
      rst_req_q <= rst_req_d;
    end
  end

  // Zero-latency read mux
  always_comb begin
    Dout = '0;
    case (ADDR[3:2])
      OFF_CTRL:  Dout = ctrl_readback(state_q, en_q, im_q, rsten_q);
      OFF_LOAD:  Dout = load_q;
      OFF_COUNT: Dout = count_q;
      default:   Dout = '0;
    endcase
  end

  assign IRQ     = irq_q;
  assign rst_req = rst_req_q;

endmodule
